uart_fifo_ctrl: RTL

Sequences the single-port, 1-cycle-read-latency UART FIFO BRAM (one shared address, write enable, registered read data) as a first-in first-out queue.
Presents valid/ready push and pop streams and holds the read/write pointers and occupancy.
Arbitrates the single memory port between writes and prefetch reads, and keeps one output holding register.
Sits between the UART RX/TX logic and the BRAM instance.

---
 rtl/uart_fifo_ctrl.sv | 97 +++++++++
 1 files changed

// File: rtl/uart_fifo_ctrl.sv
// FIFO sequencer for a single-port BRAM with 1-cycle registered read data.
// Writes and prefetch reads share the port; the head entry sits in an output register.
module uart_fifo_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rd
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  prio_q, prio_d;
    logic                  live_q;
    logic                  pop_fire, fetch_req, write, fetch;

    assign pop_fire   = out_valid_q & pop_ready;
    assign fetch_req  = (cnt_q != '0) & !inflight_q & (!out_valid_q | pop_fire) & !flush;
    // live_q keeps push_ready low until the first clock after reset release
    assign push_ready = live_q & !flush & (cnt_q != FULL_CNT) & (!fetch_req | prio_q);
    assign write      = push_valid & push_ready;
    assign fetch      = fetch_req & !write;

    assign mem_wen   = write;
    assign mem_wd    = push_data;
    assign mem_addr  = write ? wr_ptr_q : rd_ptr_q;
    assign pop_valid = out_valid_q;
    assign pop_data  = out_data_q;
    assign level     = {1'b0, cnt_q} + {{(ADDR_WIDTH+1){1'b0}}, inflight_q}
                     + {{(ADDR_WIDTH+1){1'b0}}, out_valid_q};

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, write};
        rd_ptr_d    = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, fetch};
        cnt_d       = cnt_q + {{ADDR_WIDTH{1'b0}}, write} - {{ADDR_WIDTH{1'b0}}, fetch};
        inflight_d  = fetch;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        prio_d      = prio_q;
        // A landing read wins over a same-cycle pop clear
        if (inflight_q) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_rd;
        end else if (pop_fire) begin
            out_valid_d = 1'b0;
        end
        if (write)      prio_d = 1'b0;
        else if (fetch) prio_d = 1'b1;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            inflight_d  = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
            prio_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            prio_q      <= 1'b1;
            live_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            prio_q      <= prio_d;
            live_q      <= 1'b1;
        end
    end
endmodule
